// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and defaults for the data-memory responder.
//   state_t            FSM state encoding (IDLE, WAIT, RESP)
//   DEF_DEPTH_WORDS    default number of 32-bit words in the store
//   DEF_LATENCY        default request-to-response latency in cycles
//   CNT_W              latency counter width (LATENCY up to 15)
//   addr_err()         misalignment / out-of-range check for a byte address
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_LATENCY     = 2;
  localparam int CNT_W           = 4;

  // A word access is legal only when word aligned and inside the store.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between a pipeline (master) and the
// data-memory responder (slave).
//   req_valid/req_ready   request handshake
//   req_we                1 = store, 0 = load
//   req_addr              byte address
//   req_wdata, req_be     store data and byte enables (bit i -> bits 8i+7:8i)
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    load data (0 for stores/errors) and error flag
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port word store, byte-enable write, combinational read.
//   clk     clock
//   we      write strobe (bytes selected by be)
//   addr    word index
//   wdata   write data
//   be      byte enables
//   rdata   word at addr (combinational)
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);

  // One byte-wide array per lane keeps each storage element driven by a
  // single process while still allowing partial-word writes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          lane_mem[addr] <= wdata[8*gi +: 8];
        end
      end

      assign rdata[8*gi +: 8] = lane_mem[addr];
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed
// request-to-response latency.
//   clk   clock
//   rst   synchronous active-high reset
//   bus   dmem_if.slave (request and response handshakes)
// A request accepted at edge N produces rsp_valid from edge N+LATENCY.
// The access is committed on the edge that enters RESP, so a later load
// always sees earlier stores.  LATENCY must lie in 1..15.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               we_reg, we_next;
  logic [31:0]        addr_reg, addr_next;
  logic [31:0]        wdata_reg, wdata_next;
  logic [3:0]         be_reg, be_next;
  logic               rsp_valid_reg, rsp_valid_next;
  logic [31:0]        rsp_rdata_reg, rsp_rdata_next;
  logic               rsp_err_reg, rsp_err_next;

  logic               commit;
  logic               acc_err;
  logic               mem_we;
  logic [31:0]        mem_rdata;

  assign acc_err = addr_err(addr_reg, DEPTH_WORDS);
  // Faulting accesses never write; a reset on the commit edge also blocks it.
  assign mem_we  = commit && we_reg && !acc_err && !rst;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_reg[AW+1:2]),
    .wdata (wdata_reg),
    .be    (be_reg),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    we_next        = we_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    be_next        = be_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    commit         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_next    = bus.req_we;
          addr_next  = bus.req_addr;
          wdata_next = bus.req_wdata;
          be_next    = bus.req_be;
          // WAIT always lasts LATENCY edges including the commit edge;
          // with LATENCY=1 it is a single commit cycle.
          cnt_next   = CNT_W'(LATENCY - 1);
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_reg == '0) begin
          commit         = 1'b1;
          rsp_valid_next = 1'b1;
          rsp_err_next   = acc_err;
          rsp_rdata_next = (acc_err || we_reg) ? 32'h0 : mem_rdata;
          state_next     = ST_RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_next = 1'b0;
          rsp_rdata_next = 32'h0;
          rsp_err_next   = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      we_reg        <= 1'b0;
      addr_reg      <= 32'h0;
      wdata_reg     <= 32'h0;
      be_reg        <= 4'h0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'h0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      be_reg        <= be_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  assign bus.req_ready = (state_reg == ST_IDLE) && !rst;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;

endmodule
